// File: rtl/err_display_scan.sv
// Multiplexed seven-segment error display: latches the highest-priority fault as a code,
// scans "Er" plus the hex code, blinks until acknowledged and enforces a minimum hold time.
module err_display_scan #(
    parameter int unsigned NUM_ERR      = 8,
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned SCAN_DIV     = 1000,
    parameter int unsigned HOLD_FRAMES  = 50,
    parameter int unsigned BLINK_FRAMES = 25
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_ERR-1:0]              err_flags,
    input  logic                            ack,
    output logic [6:0]                      seg,
    output logic [NUM_DIGITS-1:0]           dig_sel,
    output logic [$clog2(NUM_ERR+1)-1:0]    err_code,
    output logic                            err_active
);

    localparam int unsigned CW  = $clog2(NUM_ERR + 1);
    localparam int unsigned PW  = $clog2(SCAN_DIV);
    localparam int unsigned DW  = $clog2(NUM_DIGITS);
    localparam int unsigned HW  = $clog2(HOLD_FRAMES + 2);
    localparam int unsigned BW  = $clog2(BLINK_FRAMES + 2);
    localparam int unsigned CEW = 4 * (NUM_DIGITS - 2);

    localparam logic [6:0] SegE = 7'b1001111;
    localparam logic [6:0] SegR = 7'b0000101;

    typedef enum logic [1:0] {StIdle, StShow, StAcked} state_e;

    state_e                 state_q, state_d;
    logic [PW-1:0]          presc_q, presc_d;
    logic [DW-1:0]          dig_q, dig_d;
    logic [CW-1:0]          code_q, code_d;
    logic [HW-1:0]          hold_q, hold_d;
    logic [BW-1:0]          blink_cnt_q, blink_cnt_d;
    logic                   blink_on_q, blink_on_d;
    logic [6:0]             seg_q, seg_d;
    logic [NUM_DIGITS-1:0]  dig_sel_q, dig_sel_d;

    logic          tick, frame_end, any_flag, cur_flag, latch;
    logic [CW-1:0] new_code;
    logic [CEW-1:0] code_ext;
    logic [3:0]    nibble;
    logic [6:0]    content;
    int            shamt;

    function automatic logic [6:0] hex_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1111110;
            4'h1: s = 7'b0110000;
            4'h2: s = 7'b1101101;
            4'h3: s = 7'b1111001;
            4'h4: s = 7'b0110011;
            4'h5: s = 7'b1011011;
            4'h6: s = 7'b1011111;
            4'h7: s = 7'b1110000;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1111011;
            4'hA: s = 7'b1110111;
            4'hB: s = 7'b0011111;
            4'hC: s = 7'b1001110;
            4'hD: s = 7'b0111101;
            4'hE: s = 7'b1001111;
            default: s = 7'b1000111;
        endcase
        return s;
    endfunction

    // Scan timing runs in every state.
    always_comb begin
        tick      = (presc_q == PW'(SCAN_DIV - 1));
        frame_end = tick && (dig_q == DW'(NUM_DIGITS - 1));
        presc_d   = tick ? '0 : presc_q + 1'b1;
        dig_d     = dig_q;
        if (tick) begin
            dig_d = (dig_q == DW'(NUM_DIGITS - 1)) ? '0 : dig_q + 1'b1;
        end
    end

    always_comb begin
        any_flag = |err_flags;
        new_code = '0;
        for (int i = NUM_ERR - 1; i >= 0; i--) begin
            if (err_flags[i]) new_code = CW'(i + 1);
        end
        cur_flag = 1'b0;
        for (int i = 0; i < NUM_ERR; i++) begin
            if (code_q == CW'(i + 1)) cur_flag = err_flags[i];
        end
    end

    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        hold_d      = hold_q;
        blink_cnt_d = blink_cnt_q;
        blink_on_d  = blink_on_q;
        latch       = 1'b0;

        if (state_q != StIdle && frame_end && hold_q != HW'(HOLD_FRAMES)) begin
            hold_d = hold_q + 1'b1;
        end
        if (state_q == StShow && frame_end) begin
            if (int'(blink_cnt_q) + 1 >= int'(BLINK_FRAMES)) begin
                blink_on_d  = ~blink_on_q;
                blink_cnt_d = '0;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end

        // Preemption beats release, release beats ack.
        case (state_q)
            StIdle: begin
                if (any_flag) latch = 1'b1;
            end
            StShow, StAcked: begin
                if (any_flag && new_code < code_q) begin
                    latch = 1'b1;
                end else if (hold_q == HW'(HOLD_FRAMES) && !cur_flag) begin
                    if (any_flag) begin
                        latch = 1'b1;
                    end else begin
                        state_d     = StIdle;
                        code_d      = '0;
                        hold_d      = '0;
                        blink_cnt_d = '0;
                        blink_on_d  = 1'b1;
                    end
                end else if (state_q == StShow && ack) begin
                    state_d    = StAcked;
                    blink_on_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (latch) begin
            state_d     = StShow;
            code_d      = new_code;
            hold_d      = '0;
            blink_cnt_d = '0;
            blink_on_d  = 1'b1;
        end
    end

    always_comb begin
        code_ext = CEW'(code_q);
        shamt    = 4 * (int'(NUM_DIGITS) - 1 - int'(dig_q));
        nibble   = 4'(code_ext >> shamt);
        case (dig_q)
            DW'(0):  content = SegE;
            DW'(1):  content = SegR;
            default: content = hex_seg(nibble);
        endcase

        seg_d     = '0;
        dig_sel_d = '0;
        if (state_q != StIdle) begin
            dig_sel_d = NUM_DIGITS'(1) << dig_q;
            if (!(state_q == StShow && !blink_on_q)) seg_d = content;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            presc_q     <= '0;
            dig_q       <= '0;
            code_q      <= '0;
            hold_q      <= '0;
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
            seg_q       <= '0;
            dig_sel_q   <= '0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            dig_q       <= dig_d;
            code_q      <= code_d;
            hold_q      <= hold_d;
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
            seg_q       <= seg_d;
            dig_sel_q   <= dig_sel_d;
        end
    end

    assign seg        = seg_q;
    assign dig_sel    = dig_sel_q;
    assign err_code   = code_q;
    assign err_active = (state_q != StIdle);

endmodule
